// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction fetch path
package mips_pkg;

    localparam int INST_W = 32;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT,
        S_FAULT
    } fetch_state_t;

    // Instructions are word aligned; any set low bit marks an illegal PC.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decode handshake bundle for fetch_unit
interface fetch_unit_if #(
    parameter int N = 32
);
    import mips_pkg::*;

    logic              imem_req_valid;
    logic [N-1:0]      imem_req_addr;
    logic              imem_req_ready;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [N-1:0]      inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register and single-outstanding instruction fetch FSM
module fetch_unit
    import mips_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC),
    parameter int           CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     next_pc,
    output logic [N-1:0]     pc,
    input  logic             halt,
    output logic             fault,
    output logic [CNT_W-1:0] instret,
    fetch_unit_if.master     bus
);

    fetch_state_t      state;
    fetch_state_t      state_d;
    logic [INST_W-1:0] inst_q;
    logic              retire;

    // The held instruction retires in the cycle decode accepts it.
    assign retire = (state == S_HOLD) && bus.inst_ready;

    assign bus.imem_req_valid = (state == S_REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = (state == S_HOLD);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = pc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; halt and next_pc only matter at retire, and a
    // misaligned PC coming out of halt is caught before it is requested.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = misaligned(RESET_PC[1:0]) ? S_FAULT : S_REQ;
            S_REQ:   if (bus.imem_req_ready) state_d = S_WAIT;
            S_WAIT:  if (bus.imem_resp_valid) state_d = S_HOLD;
            S_HOLD: begin
                if (bus.inst_ready) begin
                    if (halt) begin
                        state_d = S_HALT;
                    end else if (misaligned(next_pc[1:0])) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT: begin
                if (!halt) begin
                    state_d = misaligned(pc[1:0]) ? S_FAULT : S_REQ;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // PC, captured instruction, sticky fault flag and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            inst_q  <= '0;
            fault   <= 1'b0;
            instret <= '0;
        end else begin
            if ((state == S_WAIT) && bus.imem_resp_valid) begin
                inst_q <= bus.imem_resp_data;
            end
            if (retire) begin
                pc      <= next_pc;
                instret <= instret + CNT_W'(1);
            end
            if (state_d == S_FAULT) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        rst4_n;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        halt;
    logic        fault;
    logic [31:0] instret;

    logic [31:0] next_pc4;
    logic [31:0] pc4;
    logic        fault4;
    logic [3:0]  instret4;

    logic        mem_ready;
    logic        inst_rdy;
    logic        resp_extra;
    logic        auto_np;
    logic [31:0] np_val;
    logic [31:0] mem_data;
    logic        pending;
    logic        pending4;

    int checks;
    int errors;

    fetch_unit_if #(.N(32)) bus ();
    fetch_unit_if #(.N(32)) bus4 ();

    fetch_unit #(.N(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .next_pc (next_pc),
        .pc      (pc),
        .halt    (halt),
        .fault   (fault),
        .instret (instret),
        .bus     (bus)
    );

    fetch_unit #(.N(32), .CNT_W(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst4_n),
        .next_pc (next_pc4),
        .pc      (pc4),
        .halt    (1'b0),
        .fault   (fault4),
        .instret (instret4),
        .bus     (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign next_pc             = auto_np ? pc + 32'd4 : np_val;
    assign bus.imem_req_ready  = mem_ready;
    assign bus.imem_resp_valid = pending | resp_extra;
    assign bus.imem_resp_data  = mem_data;
    assign bus.inst_ready      = inst_rdy;

    assign next_pc4             = pc4 + 32'd4;
    assign bus4.imem_req_ready  = 1'b1;
    assign bus4.imem_resp_valid = pending4;
    assign bus4.imem_resp_data  = 32'h0000_0013;
    assign bus4.inst_ready      = 1'b1;

    // Memory model: one-cycle response pulse the cycle after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= 1'b0;
        else        pending <= bus.imem_req_valid && bus.imem_req_ready;
    end

    always @(posedge clk or negedge rst4_n) begin
        if (!rst4_n) pending4 <= 1'b0;
        else         pending4 <= bus4.imem_req_valid && bus4.imem_req_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        mem_ready  = 1'b0;
        inst_rdy   = 1'b0;
        halt       = 1'b0;
        resp_extra = 1'b0;
        auto_np    = 1'b0;
        np_val     = 32'h0;
        mem_data   = 32'h2000_0001;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_inst(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.inst_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_inst: inst_valid=0 required 1 within 20 cycles");
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 00000000", bus.inst); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.imem_req_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] addr_log [3];
        int          cyc_log  [3];
        int          acc;
        int          ret;
        bit          done;
        do_reset();
        mem_ready = 1'b1;
        inst_rdy  = 1'b1;
        auto_np   = 1'b1;
        acc  = 0;
        ret  = 0;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.imem_req_valid && mem_ready && acc < 3) begin
                addr_log[acc] = bus.imem_req_addr;
                cyc_log[acc]  = c;
                acc++;
            end
            if (bus.inst_valid && inst_rdy) begin
                if (ret == 0) begin
                    checks++; if (bus.inst !== 32'h2000_0001) begin errors++; $display("FAIL seq_inst: got %h want 20000001", bus.inst); end
                    checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL seq_inst_pc: got %h want 00000000", bus.inst_pc); end
                end
                ret++;
            end
            tick();
            if (ret == 3) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done || acc != 3) begin
            errors++;
            $display("FAIL seq_timeout: retires=%0d accepts=%0d want 3 and 3", ret, acc);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (addr_log[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, addr_log[i], 32'(4 * i)); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (cyc_log[i] - cyc_log[i-1] != 3) begin errors++; $display("FAIL seq_spacing%0d: got %0d want 3", i, cyc_log[i] - cyc_log[i-1]); end
            end
            checks++; if (instret !== 32'd3) begin errors++; $display("FAIL seq_instret: got %0d want 3", instret); end
            checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq_pc: got %h want 0000000c", pc); end
        end
    endtask

    task automatic test_stall();
        int acc;
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b want 1", i, bus.imem_req_valid); end
            checks++; if (bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL stall_addr%0d: got %h want 00000000", i, bus.imem_req_addr); end
            tick();
        end
        mem_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.imem_req_valid && mem_ready) acc++;
            tick();
        end
        checks++; if (acc != 1) begin errors++; $display("FAIL stall_accepts: got %0d want 1", acc); end
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b want 1", bus.inst_valid); end
    endtask

    task automatic test_hold_stable();
        bit ok;
        do_reset();
        mem_ready = 1'b1;
        np_val    = 32'h40;
        mem_data  = 32'h1234_5678;
        wait_inst(ok);
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d: got %b want 1", i, bus.inst_valid); end
            checks++; if (bus.inst !== 32'h1234_5678) begin errors++; $display("FAIL hold_inst%0d: got %h want 12345678", i, bus.inst); end
            checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL hold_inst_pc%0d: got %h want 00000000", i, bus.inst_pc); end
            checks++; if (pc !== 32'h0) begin errors++; $display("FAIL hold_pc%0d: got %h want 00000000", i, pc); end
            np_val = (i % 2 == 0) ? 32'h80 : 32'h40;
            tick();
        end
        np_val   = 32'h80;
        inst_rdy = 1'b1;
        tick();
        inst_rdy = 1'b0;
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL hold_retire_pc: got %h want 00000080", pc); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL hold_after_retire: got %b want 0", bus.inst_valid); end
    endtask

    task automatic test_fault();
        bit ok;
        int reqs;
        do_reset();
        mem_ready = 1'b1;
        inst_rdy  = 1'b1;
        np_val    = 32'h0000_0102;
        wait_inst(ok);
        tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b want 1", fault); end
        checks++; if (pc !== 32'h102) begin errors++; $display("FAIL fault_pc: got %h want 00000102", pc); end
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            resp_extra = (i % 2 == 0);
            if (bus.imem_req_valid || bus.inst_valid) reqs++;
            tick();
        end
        resp_extra = 1'b0;
        checks++; if (reqs != 0) begin errors++; $display("FAIL fault_quiet: got %0d active cycles want 0", reqs); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", fault); end
        checks++; if (pc !== 32'h102) begin errors++; $display("FAIL fault_pc_hold: got %h want 00000102", pc); end
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL fault_instret: got %0d want 1", instret); end
    endtask

    task automatic test_halt();
        bit ok;
        int reqs;
        do_reset();
        mem_ready = 1'b1;
        inst_rdy  = 1'b1;
        halt      = 1'b1;
        np_val    = 32'h10;
        wait_inst(ok);
        tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL halt_pc: got %h want 00000010", pc); end
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.imem_req_valid) reqs++;
            tick();
        end
        checks++; if (reqs != 0) begin errors++; $display("FAIL halt_quiet: got %0d requests want 0", reqs); end
        halt = 1'b0;
        tick();
        checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL resume_valid: got %b want 1", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== 32'h10) begin errors++; $display("FAIL resume_addr: got %h want 00000010", bus.imem_req_addr); end
    endtask

    task automatic test_wrap();
        int  ret;
        bit  done;
        rst4_n = 1'b0;
        tick();
        rst4_n = 1'b1;
        ret  = 0;
        done = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (bus4.inst_valid) begin
                if (ret == 15) begin
                    checks++; if (instret4 !== 4'd15) begin errors++; $display("FAIL wrap_pre: got %0d want 15", instret4); end
                end
                ret++;
            end
            tick();
            if (ret == 16) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wrap_timeout: retires=%0d want 16", ret);
        end else if (instret4 !== 4'd0) begin
            errors++;
            $display("FAIL wrap_instret: got %0d want 0", instret4);
        end
        rst4_n = 1'b0;
    endtask

    task automatic test_async_reset();
        bit done;
        do_reset();
        mem_ready = 1'b1;
        inst_rdy  = 1'b1;
        auto_np   = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (instret == 32'd1 && bus.imem_req_valid && mem_ready) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!done) begin errors++; $display("FAIL areset_setup: instret=%0d did not reach second request", instret); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL areset_pc: got %h want 00000000", pc); end
        checks++; if (instret !== 32'h0) begin errors++; $display("FAIL areset_instret: got %0d want 0", instret); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL areset_inst: got %h want 00000000", bus.inst); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL areset_req_valid: got %b want 0", bus.imem_req_valid); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL areset_inst_valid: got %b want 0", bus.inst_valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL areset_fault: got %b want 0", fault); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        rst4_n     = 1'b0;
        mem_ready  = 1'b0;
        inst_rdy   = 1'b0;
        halt       = 1'b0;
        resp_extra = 1'b0;
        auto_np    = 1'b0;
        np_val     = 32'h0;
        mem_data   = 32'h2000_0001;
        test_reset();
        test_sequential();
        test_stall();
        test_hold_stable();
        test_fault();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Holds the architectural PC register and fetches one instruction at a time from instruction memory over a valid/ready request and response interface.
- Presents the fetched instruction and its PC to decode, and waits for decode to accept it.
- Sits directly downstream of pc_control: it drives pc into pc_control and latches pc_control's next_pc when the current instruction retires.
- Single outstanding request. Includes a misalignment fault stop and a retired-instruction counter.

Parameters:
- N, 32, datapath/address width (matches pc_control).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- next_pc  input  N  next PC from pc_control, sampled only on retire
- pc  output  N  current PC register, feeds pc_control
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  N  fetch address (= pc)
- imem_req_ready  input  1  memory accepts request
- imem_resp_valid  input  1  instruction data valid (one-cycle pulse)
- imem_resp_data  input  32  instruction word
- inst_valid  output  1  instruction available to decode
- inst  output  32  registered instruction word
- inst_pc  output  N  PC of inst (= pc)
- inst_ready  input  1  decode accepts/retires instruction this cycle
- halt  input  1  stop fetching after the current instruction retires
- fault  output  1  sticky misaligned-PC fault
- instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n low, async):
  - pc=RESET_PC, state=S_IDLE, inst=0, fault=0, instret=0.
  - imem_req_valid=0, inst_valid=0.
- States:
  - S_IDLE: next cycle goes to S_REQ, unless RESET_PC[1:0]!=0, in which case it goes to S_FAULT and fault=1.
  - S_REQ: imem_req_valid=1 and imem_req_addr=pc. On imem_req_ready it goes to S_WAIT; otherwise it holds with addr stable.
  - S_WAIT: on imem_resp_valid, inst<=imem_resp_data and the block goes to S_HOLD.
  - S_HOLD: inst_valid=1. On inst_valid&&inst_ready (retire):
    - pc<=next_pc and instret<=instret+1 (wraps modulo 2^CNT_W).
    - If halt=1, go to S_HALT.
    - Else if next_pc[1:0]!=0, go to S_FAULT with fault<=1.
    - Else go to S_REQ.
  - S_HALT: no requests. When halt deasserts, go to S_REQ at the current pc.
  - S_FAULT: terminal until reset. No requests, inst_valid=0, pc holds the faulting address.
- Latency:
  - Minimum 3 cycles per instruction: REQ, WAIT, HOLD, assuming ready/resp arrive immediately.
  - Memory must not return the response in the same cycle the request is accepted.
- imem_resp_valid outside S_WAIT is ignored; no state change.
- inst and inst_pc are stable for the whole of S_HOLD. inst_valid never drops without inst_ready.
- halt is sampled only at retire. Halt with a misaligned next_pc goes to S_HALT; the fault is raised on resume, going S_REQ→S_FAULT check in S_HALT exit.
- pc changes only on retire or reset. next_pc is ignored in all other cycles.
- Reset asserted mid-request abandons the transaction. Memory is required to drop any in-flight response on rst_n low.

Decomposition:
- mips_pkg:
  - fetch_state_t enum (S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT, S_FAULT).
  - RESET_PC default constant.
  - INST_W=32.
- No sub-module. The counter and FSM are kept in one module, with pc_control instantiated alongside at the top level.

Test Plan:
- Reset release, memory always ready with 1-cycle response 0x2000_0001, inst_ready=1, next_pc=pc+4:
  - Requests at 0x0, 0x4, 0x8, each 3 cycles apart.
  - instret=3 after third retire.
- imem_req_ready held low for 4 cycles:
  - imem_req_valid stays 1 with addr 0x0 constant.
  - Request accepted on the 5th cycle; no duplicate request.
- inst_ready low for 5 cycles in S_HOLD, next_pc toggling 0x40/0x80:
  - inst and inst_pc stable.
  - pc updates to the value of next_pc in the retire cycle only.
- Retire with next_pc=0x0000_0102:
  - fault=1, no further imem_req_valid, pc=0x102.
  - Subsequent inst_ready and resp pulses have no effect until reset.
- halt=1 at retire with next_pc=0x10:
  - pc=0x10 and requests stop.
  - After halt deasserts, the first request is addr 0x10.
- instret preloaded near wrap via CNT_W=4:
  - 16 retires bring instret back to 0.
- Async reset asserted mid S_WAIT:
  - All outputs return to reset values immediately.
